seg7_scroll_driver: RTL and testbench
=====================================

# seg7_scroll_driver

Parametrised multiplexed 7-segment driver that stores a hex message of MSG_LEN characters and shows a DIGITS-wide window of it on a common-anode display, scanning one digit at a time. It rotates the window left or right by one character every SHIFT_FRAMES complete scan frames and blanks the display between digit slots to suppress ghosting. It sits between the message-producing logic and the board's anode/segment pins and includes the single-digit hex-to-segment decode.

## Interface
- DIGITS, 4: number of physical digits, ≥1.
- MSG_LEN, 16: message buffer depth in 4-bit characters, ≥DIGITS. Need not be a power of two.
- REFRESH_DIV, 16384: clock cycles per digit slot, ≥2.
- BLANK, 1024: cycles at the start of each slot with all anodes off. Must satisfy 0 ≤ BLANK < REFRESH_DIV.
- SHIFT_FRAMES, 64: completed frames per rotation step, ≥1.
- SEG_ACTIVE_LOW, 1: 1 means seg is emitted as decoded (0 = lit). 0 means seg is inverted.
- clk, input, 1: the single clock. All state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- wr_en, input, 1: writes wr_data into buffer[wr_addr] on this edge.
- wr_addr, input, clog2(MSG_LEN): write address. Writes with wr_addr ≥ MSG_LEN are ignored.
- wr_data, input, 4: hex character.
- rot_en, input, 1: rotation enable, sampled at the frame end.
- rot_dir, input, 1: 0 = offset+1 (text moves left), 1 = offset−1.
- offset_clr, input, 1: forces offset to 0 and clears the frame counter.
- an, output, DIGITS: anode enables, active low. an[DIGITS-1] drives the leftmost digit.
- seg, output, 7: segments {a,b,c,d,e,f,g}, with a as the MSB.
- step, output, 1: one-cycle pulse on the cycle after the offset changes because of rotation.

## Operation
- Counters:
  - cnt runs 0..REFRESH_DIV-1.
  - k (digit index, 0 = leftmost) runs 0..DIGITS-1.
  - fcnt runs 0..SHIFT_FRAMES-1.
  - cnt wraps to 0 and advances k. k wraps after DIGITS-1, which completes a frame.
- Frame end is the cycle where k=DIGITS-1 and cnt=REFRESH_DIV-1.
- Character latch: when cnt=0, latch ch = buffer[(offset+k) mod MSG_LEN]. Compute the index by compare/subtract, with no modulo operator. A write to the displayed address mid-slot appears on the next visit to that digit.
- Decode table (active-low, SEG_ACTIVE_LOW=1):
  - 0: 0000001; 1: 1001111; 2: 0010010; 3: 0000110
  - 4: 1001100; 5: 0100100; 6: 0100000; 7: 0001111
  - 8: 0000000; 9: 0000100; A: 0001000; b: 1100000
  - C: 0110001; d: 1000010; E: 0110000; F: 0111000
- Anodes:
  - cnt < BLANK: an = all ones.
  - Otherwise: an is one-hot low at bit DIGITS-1-k.
  - seg always shows the decode of ch.
- Rotation at frame end, in priority order:
  1. offset_clr=1: offset←0, fcnt←0, no step.
  2. Else rot_en=0: fcnt and offset hold.
  3. Else fcnt<SHIFT_FRAMES-1: fcnt+1.
  4. Else: fcnt←0 and offset steps by ±1. +1 wraps MSG_LEN-1→0. −1 wraps 0→MSG_LEN-1. step pulses.
- offset_clr outside frame end: offset←0, fcnt←0 immediately. The new offset takes effect at the next cnt=0 latch.
- Write during the same cycle as a latch of the same address: the latch sees the old data.

## Timing
- Reset state:
  - Outputs: an = all ones, seg = 1111111 (0000000 if SEG_ACTIVE_LOW=0), step=0.
  - Internal: cnt=0, k=0, fcnt=0, offset=0, ch=0.
  - buffer[i] = i mod 16.
- First cycle after reset_n deasserts: cnt=0, k=0.
- an, seg and step are registered. Each reflects the cnt/k/ch state one cycle later (latency 1).
- Slot timing:
  - The first lit anode appears BLANK+1 cycles after the slot's cnt=0 edge.
  - Each digit is lit for REFRESH_DIV−BLANK cycles.
  - One frame is DIGITS·REFRESH_DIV cycles.
- Rotation period with rot_en held high is SHIFT_FRAMES frames.
- The new offset is first visible in the k=0 latch of the following frame.
- Reset asserted mid-frame returns everything to the reset state asynchronously, including buffer contents.

## Test plan
Bench parameters: DIGITS=4, MSG_LEN=6, REFRESH_DIV=4, BLANK=1, SHIFT_FRAMES=2.

- **Reset and scan:** reset release with rot_en=0 gives:
  - per 4-cycle slot, one blank cycle (an=1111), then three cycles of an=0111 with seg=0000001 ('0');
  - then an=1011 with '1', an=1101 with '2', an=1110 with '3';
  - the pattern repeats every 16 cycles.
- **Decode sweep:** write 0..F over the buffer and window → every seg value matches the table; with SEG_ACTIVE_LOW=0, seg is inverted.
- **Left rotation wrap:** rot_en=1, rot_dir=0 → step pulses every 32 cycles. Offsets go 1,2,3,4,5,0. At offset 4 the digits show 4,5,0,1.
- **Right rotation wrap:** rot_dir=1 from offset 0 → offset 5; the window shows 5,0,1,2.
- **Clear vs step:** offset_clr=1 and a pending step at the same frame end → offset=0, step stays 0, fcnt=0.
- **Write hazards:**
  - A write to the address being latched on the cnt=0 cycle → old value shown this visit, new value next frame.
  - A write with wr_addr=6 or 7 → no buffer change.
  - reset_n pulled low mid-slot → an=1111 immediately and buffer restored to 0..5.

Source files
------------

// File: rtl/seg7_scroll_driver.sv
// Multiplexed common-anode 7-segment driver showing a rotating DIGITS-wide
// window of a hex message buffer, with per-slot anode blanking.
module seg7_scroll_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned MSG_LEN        = 16,
  parameter int unsigned REFRESH_DIV    = 16384,
  parameter int unsigned BLANK          = 1024,
  parameter int unsigned SHIFT_FRAMES   = 64,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  localparam int unsigned AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [3:0]        wr_data,
  input  logic              rot_en,
  input  logic              rot_dir,
  input  logic              offset_clr,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              step
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam int unsigned KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FW = (SHIFT_FRAMES > 1) ? $clog2(SHIFT_FRAMES) : 1;
  localparam int unsigned IW = AW + 1;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [KW-1:0]     k_q, k_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [AW-1:0]     off_q, off_d;
  logic [3:0]        ch_q, ch_d;
  logic [3:0]        buf_q [MSG_LEN];
  logic [3:0]        buf_d [MSG_LEN];
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              step_q, step_d;

  logic          last_cnt, last_k, frame_end, wr_ok;
  logic [IW-1:0] idx_sum;
  logic [AW-1:0] rd_idx;
  logic [6:0]    dec;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Scan counters, character latch, buffer writes and rotation
  always_comb begin
    last_cnt  = (cnt_q == CW'(REFRESH_DIV - 1));
    last_k    = (k_q == KW'(DIGITS - 1));
    frame_end = last_cnt && last_k;

    cnt_d = cnt_q + CW'(1);
    k_d   = k_q;
    if (last_cnt) begin
      cnt_d = '0;
      k_d   = last_k ? '0 : k_q + KW'(1);
    end

    // offset+k < 2*MSG_LEN, so one conditional subtract wraps it
    idx_sum = IW'(off_q) + IW'(k_q);
    if (idx_sum >= IW'(MSG_LEN)) idx_sum = idx_sum - IW'(MSG_LEN);
    rd_idx = AW'(idx_sum);
    ch_d   = (cnt_q == '0) ? buf_q[rd_idx] : ch_q;

    wr_ok = wr_en && (IW'(wr_addr) < IW'(MSG_LEN));
    for (int i = 0; i < MSG_LEN; i++) begin
      buf_d[i] = buf_q[i];
      if (wr_ok && (wr_addr == AW'(i))) buf_d[i] = wr_data;
    end

    off_d  = off_q;
    fcnt_d = fcnt_q;
    step_d = 1'b0;
    if (offset_clr) begin
      off_d  = '0;
      fcnt_d = '0;
    end else if (frame_end && rot_en) begin
      if (fcnt_q < FW'(SHIFT_FRAMES - 1)) begin
        fcnt_d = fcnt_q + FW'(1);
      end else begin
        fcnt_d = '0;
        step_d = 1'b1;
        if (rot_dir) off_d = (off_q == '0) ? AW'(MSG_LEN - 1) : off_q - AW'(1);
        else         off_d = (off_q == AW'(MSG_LEN - 1)) ? '0 : off_q + AW'(1);
      end
    end

    if (cnt_q < CW'(BLANK)) an_d = '1;
    else                    an_d = ~(DIGITS'(1) << (KW'(DIGITS - 1) - k_q));

    dec   = hex_to_seg(ch_q);
    seg_d = (SEG_ACTIVE_LOW != 0) ? dec : ~dec;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      k_q    <= '0;
      fcnt_q <= '0;
      off_q  <= '0;
      ch_q   <= '0;
      for (int i = 0; i < MSG_LEN; i++) buf_q[i] <= 4'(i);
      an_q   <= '1;
      seg_q  <= (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      k_q    <= k_d;
      fcnt_q <= fcnt_d;
      off_q  <= off_d;
      ch_q   <= ch_d;
      for (int i = 0; i < MSG_LEN; i++) buf_q[i] <= buf_d[i];
      an_q   <= an_d;
      seg_q  <= seg_d;
      step_q <= step_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign step = step_q;

endmodule

// File: tb/tb_seg7_scroll_driver.sv
// Directed bench for seg7_scroll_driver: scan, decode, rotation, clear and
// write/reset hazards, using DIGITS=4, MSG_LEN=6, REFRESH_DIV=4, BLANK=1.
module tb_seg7_scroll_driver;

  logic       clk = 1'b0;
  logic       reset_n, wr_en, rot_en, rot_dir, offset_clr;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] an, an_inv;
  logic [6:0] seg, seg_inv;
  logic       step, step_inv;

  always #5 clk = ~clk;

  seg7_scroll_driver #(.DIGITS(4), .MSG_LEN(6), .REFRESH_DIV(4), .BLANK(1),
                       .SHIFT_FRAMES(2), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rot_en(rot_en), .rot_dir(rot_dir),
    .offset_clr(offset_clr), .an(an), .seg(seg), .step(step));

  seg7_scroll_driver #(.DIGITS(4), .MSG_LEN(6), .REFRESH_DIV(4), .BLANK(1),
                       .SHIFT_FRAMES(2), .SEG_ACTIVE_LOW(0)) dut_inv (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rot_en(rot_en), .rot_dir(rot_dir),
    .offset_clr(offset_clr), .an(an_inv), .seg(seg_inv), .step(step_inv));

  logic [6:0] dec_tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int   n_checks = 0;
  int   n_errors = 0;
  int   n;
  int   moff, mfc;
  int   mbuf [6];
  logic mstep;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; moff = 0; mfc = 0; mstep = 1'b0;
    for (int i = 0; i < 6; i++) mbuf[i] = i;
  endtask

  // Advance one clock; the reference model consumes the inputs seen at the edge
  task automatic tick();
    bit fe;
    fe    = (n % 16 == 15);
    mstep = 1'b0;
    if (wr_en && wr_addr < 3'd6) mbuf[wr_addr] = int'(wr_data);
    if (offset_clr) begin
      moff = 0; mfc = 0;
    end else if (fe && rot_en) begin
      if (mfc < 1) mfc++;
      else begin
        mfc = 0; mstep = 1'b1;
        if (rot_dir) moff = (moff == 0) ? 5 : moff - 1;
        else         moff = (moff == 5) ? 0 : moff + 1;
      end
    end
    @(posedge clk); #1;
    n++;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = 3'(a); wr_data = 4'(d);
    tick();
    wr_en = 1'b0;
  endtask

  // Checks one whole frame; optionally writes at the cnt=0 edge of slot wr_k
  // and/or raises offset_clr on the frame-end cycle
  task automatic run_frame(input string tag, input int wr_k, input int wa,
                           input int wd, input bit clr_end);
    int dig [4];
    int s, c, kk;
    logic [3:0] exp_an;
    logic [6:0] exp_seg, exp_inv;
    while (n % 16 != 0) tick();
    for (int j = 0; j < 4; j++) dig[j] = mbuf[(moff + j) % 6];
    for (int i = 0; i < 16; i++) begin
      if (wr_k >= 0 && i == 4 * wr_k) begin
        wr_en = 1'b1; wr_addr = 3'(wa); wr_data = 4'(wd);
      end
      if (clr_end && i == 15) offset_clr = 1'b1;
      tick();
      wr_en = 1'b0; offset_clr = 1'b0;
      s = n - 1; c = s % 4; kk = (s / 4) % 4;
      if (c < 1) begin
        check($sformatf("%s.an_blank[%0d]", tag, i), {4'h0, an}, 8'h0F);
      end else begin
        exp_an  = ~(4'b0001 << (3 - kk));
        exp_seg = dec_tbl[dig[kk]];
        exp_inv = ~exp_seg;
        check($sformatf("%s.an[%0d]", tag, i), {4'h0, an}, {4'h0, exp_an});
        check($sformatf("%s.seg[%0d]", tag, i), {1'b0, seg}, {1'b0, exp_seg});
        check($sformatf("%s.seg_inv[%0d]", tag, i), {1'b0, seg_inv}, {1'b0, exp_inv});
      end
      check($sformatf("%s.step[%0d]", tag, i), {7'h0, step}, {7'h0, mstep});
    end
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rot_en = 1'b0; rot_dir = 1'b0; offset_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst.an", {4'h0, an}, 8'h0F);
    check("rst.seg", {1'b0, seg}, 8'h7F);
    check("rst.seg_inv", {1'b0, seg_inv}, 8'h00);
    check("rst.step", {7'h0, step}, 8'h00);
    reset_n = 1'b1;
    model_reset();

    run_frame("scan0", -1, 0, 0, 1'b0);
    run_frame("scan1", -1, 0, 0, 1'b0);

    rot_en = 1'b1; rot_dir = 1'b0;
    for (int f = 0; f < 12; f++) run_frame($sformatf("rotl%0d", f), -1, 0, 0, 1'b0);

    rot_dir = 1'b1;
    for (int f = 0; f < 4; f++) run_frame($sformatf("rotr%0d", f), -1, 0, 0, 1'b0);
    run_frame("clr_vs_step", -1, 0, 0, 1'b1);
    for (int f = 0; f < 3; f++) run_frame($sformatf("after_clr%0d", f), -1, 0, 0, 1'b0);
    rot_en = 1'b0;

    offset_clr = 1'b1; tick(); offset_clr = 1'b0;
    run_frame("hz_old", 1, 1, 9, 1'b0);
    run_frame("hz_new", -1, 0, 0, 1'b0);
    wr(6, 15);
    wr(7, 15);
    run_frame("hz_oob", -1, 0, 0, 1'b0);

    for (int g = 0; g < 4; g++) begin
      for (int j = 0; j < 4; j++) wr(j, 4 * g + j);
      run_frame($sformatf("dec%0d", g), -1, 0, 0, 1'b0);
    end

    while (n % 4 != 2) tick();
    reset_n = 1'b0;
    #1;
    check("midrst.an", {4'h0, an}, 8'h0F);
    check("midrst.seg", {1'b0, seg}, 8'h7F);
    check("midrst.seg_inv", {1'b0, seg_inv}, 8'h00);
    check("midrst.step", {7'h0, step}, 8'h00);
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    run_frame("post_rst", -1, 0, 0, 1'b0);
    rot_en = 1'b1; rot_dir = 1'b1;
    for (int f = 0; f < 3; f++) run_frame($sformatf("post_rst_rot%0d", f), -1, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
